// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store sequencer between the execute/memory stage and a single-port
//   32-bit data memory with combinational read data. Accepts one byte,
//   halfword or word access per handshake, sign/zero-extends loads,
//   performs read-modify-write for sub-word stores and flags misaligned
//   or illegal-size requests.
//
//   Optional feature macro: MAU_MISALIGN_TRAP_EN
//     defined   : misaligned / SIZE=11 requests complete with RSP_ERR=1 and
//                 touch no memory.
//     undefined : RSP_ERR is tied 0, misaligned addresses are forced down to
//                 natural alignment and SIZE=11 is executed as a word access.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   REQ_VALID/READY     request handshake (READY only in IDLE, 0 in reset)
//   REQ_WE              1 = store, 0 = load
//   REQ_SIZE            00 byte, 01 halfword, 10 word, 11 illegal
//   REQ_UNSIGNED        zero-extend loads when 1
//   REQ_ADDR            byte address; [ADDR_W+1:2] word, [1:0] lane
//   REQ_WDATA           right-justified store data
//   RSP_VALID           one-cycle completion pulse
//   RSP_RDATA           extended load data (0 for stores and errors)
//   RSP_ERR             error flag qualified by RSP_VALID
//   MEM_A/WE/WD/RD      memory word port

module mem_access_unit #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [1:0]        REQ_SIZE,
    input  logic              REQ_UNSIGNED,
    input  logic [31:0]       REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RSP_VALID,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERR,
    output logic [ADDR_W-1:0] MEM_A,
    output logic              MEM_WE,
    output logic [31:0]       MEM_WD,
    input  logic [31:0]       MEM_RD
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WRITE,
        ST_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    state_t            state_q,  state_d;
    logic              we_q,     we_d;
    logic [1:0]        size_q,   size_d;
    logic              uns_q,    uns_d;
    logic [1:0]        lane_q,   lane_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic [31:0]       rdata_q,  rdata_d;
    logic [ADDR_W-1:0] mem_a_q,  mem_a_d;
    logic [31:0]       mem_wd_q, mem_wd_d;
`ifdef MAU_MISALIGN_TRAP_EN
    logic              err_q,    err_d;
    logic              req_misaligned;
`endif

    logic        mem_we_c;
    logic [1:0]  req_size_eff;
    logic [1:0]  req_lane_eff;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    // Address bits above the memory window are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^REQ_ADDR[31:ADDR_W+2];

    // ------------------------------------------------------------------
    // Request decode: alignment check or alignment forcing
    // ------------------------------------------------------------------
    always_comb begin
        req_size_eff = REQ_SIZE;
        req_lane_eff = REQ_ADDR[1:0];
`ifdef MAU_MISALIGN_TRAP_EN
        unique case (REQ_SIZE)
            SZ_BYTE: req_misaligned = 1'b0;
            SZ_HALF: req_misaligned = REQ_ADDR[0];
            SZ_WORD: req_misaligned = |REQ_ADDR[1:0];
            default: req_misaligned = 1'b1;
        endcase
`else
        if (REQ_SIZE == SZ_ILL) begin
            req_size_eff = SZ_WORD;
        end
        unique case (req_size_eff)
            SZ_HALF: req_lane_eff = {REQ_ADDR[1], 1'b0};
            SZ_WORD: req_lane_eff = 2'b00;
            default: req_lane_eff = REQ_ADDR[1:0];
        endcase
`endif
    end

    // ------------------------------------------------------------------
    // Lane select / extension for loads, lane merge for sub-word stores
    // ------------------------------------------------------------------
    always_comb begin
        byte_sel = MEM_RD[{lane_q, 3'b000} +: 8];
        half_sel = MEM_RD[{lane_q[1], 4'b0000} +: 16];

        load_val = MEM_RD;
        unique case (size_q)
            SZ_BYTE: load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_val = MEM_RD;
        endcase

        merge_val = MEM_RD;
        if (size_q == SZ_BYTE) begin
            merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_val[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        lane_d   = lane_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mem_a_d  = mem_a_q;
        mem_wd_d = mem_wd_q;
`ifdef MAU_MISALIGN_TRAP_EN
        err_d    = err_q;
`endif
        mem_we_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    we_d    = REQ_WE;
                    size_d  = req_size_eff;
                    uns_d   = REQ_UNSIGNED;
                    lane_d  = req_lane_eff;
                    wdata_d = REQ_WDATA;
                    rdata_d = '0;
`ifdef MAU_MISALIGN_TRAP_EN
                    err_d   = req_misaligned;
                    if (req_misaligned) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ACCESS;
                        mem_a_d = REQ_ADDR[ADDR_W+1:2];
                        if (REQ_WE && (req_size_eff == SZ_WORD)) begin
                            mem_wd_d = REQ_WDATA;
                        end
                    end
`else
                    state_d = ST_ACCESS;
                    mem_a_d = REQ_ADDR[ADDR_W+1:2];
                    if (REQ_WE && (req_size_eff == SZ_WORD)) begin
                        mem_wd_d = REQ_WDATA;
                    end
`endif
                end
            end

            ST_ACCESS: begin
                if (!we_q) begin
                    rdata_d = load_val;
                    state_d = ST_RESP;
                end else if (size_q == SZ_WORD) begin
                    // Write data was already staged into MEM_WD at accept.
                    mem_we_c = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    // Read phase of read-modify-write; MEM_WD becomes the merge.
                    mem_wd_d = merge_val;
                    state_d  = ST_WRITE;
                end
            end

            ST_WRITE: begin
                mem_we_c = 1'b1;
                state_d  = ST_RESP;
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            lane_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
`ifdef MAU_MISALIGN_TRAP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            lane_q   <= lane_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mem_a_q  <= mem_a_d;
            mem_wd_q <= mem_wd_d;
`ifdef MAU_MISALIGN_TRAP_EN
            err_q    <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign REQ_READY = (state_q == ST_IDLE) && !RST;
    assign RSP_VALID = (state_q == ST_RESP);
    assign RSP_RDATA = (state_q == ST_RESP) ? rdata_q : '0;
`ifdef MAU_MISALIGN_TRAP_EN
    assign RSP_ERR   = (state_q == ST_RESP) && err_q;
`else
    assign RSP_ERR   = 1'b0;
`endif
    assign MEM_A     = mem_a_q;
    assign MEM_WD    = mem_wd_q;
    // Gated by RST so a reset edge can never commit a write.
    assign MEM_WE    = mem_we_c && !RST;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the execute/memory pipeline stage and the single-port data memory. Accepts one byte/halfword/word load or store per handshake and drives the memory's word port (address, write enable, write data, combinational read data). Performs sign/zero extension on loads, read-modify-write for sub-word stores, and flags misaligned accesses. The pipeline stalls on REQ_READY.

## Interface
- ADDR_W, 5: word-address width; memory depth is 2^ADDR_W words of 32 bits.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  unit can accept; high only in IDLE.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_SIZE  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- REQ_UNSIGNED  in  1  load zero-extends when 1, sign-extends when 0.
- REQ_ADDR  in  32  byte address; bits [ADDR_W+1:2] select the word, [1:0] the lane, upper bits ignored.
- REQ_WDATA  in  32  store data, right-justified.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_RDATA  out  32  extended load data; 0 for stores and errors.
- RSP_ERR  out  1  valid with RSP_VALID; misaligned or illegal size.
- MEM_A  out  ADDR_W  memory word address.
- MEM_WE  out  1  memory write enable.
- MEM_WD  out  32  memory write data.
- MEM_RD  in  32  memory read data, combinational from MEM_A.

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: REQ_READY=1. On REQ_VALID, register WE, SIZE, UNSIGNED, word index, lane and WDATA. Aligned request goes to ACCESS; misaligned/illegal request goes to RESP with error flag set.
- Alignment: halfword requires ADDR[0]=0; word requires ADDR[1:0]=00; byte is always aligned; SIZE=11 is always an error.
- ACCESS: MEM_A = registered index.
  - Load: select lane (little-endian: lane 0 = bits 7:0), extend per SIZE/UNSIGNED into RSP_RDATA register, then go to RESP.
  - Word store: MEM_WE=1, MEM_WD=WDATA, then go to RESP.
  - Sub-word store: MEM_WE=0; merge WDATA[7:0] or WDATA[15:0] into MEM_RD at the lane, store the merge in a register, then go to WRITE.
- WRITE: MEM_A held, MEM_WE=1, MEM_WD = merged word, then go to RESP.
- RESP: RSP_VALID=1, RSP_ERR = error flag, RSP_RDATA = load result (0 otherwise), then go to IDLE.
- MEM_A and MEM_WD are held at their last values outside ACCESS/WRITE. MEM_WE=0 in IDLE and RESP.
- MEM_WE is forced to 0 whenever RST=1, so a reset edge never commits a write.

## Timing
- Request accepted at edge N (REQ_VALID & REQ_READY).
- Error response: RSP_VALID during cycle N+1.
- Load, word store: memory access in cycle N+1; RSP_VALID in cycle N+2.
- Sub-word store: read in N+1, write in N+2; RSP_VALID in N+3.
- REQ_READY goes high the cycle after RESP. Next accept is earliest at the edge ending that cycle, so there is no back-to-back acceptance.
- REQ_VALID in non-IDLE states is ignored. REQ_* need not be held after acceptance.
- Reset values: state IDLE, REQ_READY=1 after reset releases (0 while RST=1), RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, MEM_A=0, MEM_WE=0, MEM_WD=0.
- Reset mid-operation: any state returns to IDLE. No response is issued for the aborted request, and no partial write occurs.
- Wrap-around: word index is truncated to ADDR_W bits. Address 0x80 with ADDR_W=5 maps to word 0.

## Configuration
- MAU_MISALIGN_TRAP_EN defined: misaligned or illegal requests produce RSP_ERR=1 with no memory access, as above.
- MAU_MISALIGN_TRAP_EN undefined:
  - RSP_ERR is tied 0.
  - Misaligned halfword/word addresses are forced down to natural alignment (clear ADDR[0] or ADDR[1:0]) and the access is performed normally.
  - SIZE=11 is treated as word.

## Test plan
- Word store 0xDEADBEEF at 0x0C, then word load 0x0C: MEM_WE pulses one cycle with MEM_A=3; load RSP_RDATA=0xDEADBEEF at N+2; RSP_ERR=0.
- Byte load: word 3 = 0x80FF7F01 at ADDR 0x0E.
  - Signed → 0xFFFFFFFF... expected value is lane 2 = 0xFF, so signed → 0xFFFFFFFF, unsigned → 0x000000FF.
  - Halfword load at 0x0E signed → 0xFFFF80FF.
- Byte store 0xAB at 0x0D onto word 0x11223344: read cycle with MEM_WE=0, then write MEM_WD=0x1122AB44; RSP_VALID at N+3.
- Halfword load at 0x05 with macro defined: RSP_VALID at N+1, RSP_ERR=1, RSP_RDATA=0, MEM_WE never asserted. Without the macro: reads word 1 lane 0–1.
- RST asserted during WRITE of a sub-word store: MEM_WE=0 that cycle, memory word unchanged, no RSP_VALID, REQ_READY=1 after release.
- Store to 0x7C (word 31), then to 0x80: the second store wraps to word 0, and word 31 retains the first value.
